edge_mode_ctrl: RTL and testbench

Control block for the camera edge-detection datapath.
- Debounces a push-button that cycles the display mode: RGB passthrough, grayscale, horizontal Sobel, vertical Sobel.
- Queues mode and threshold changes and applies them only at a frame boundary, so no frame is rendered with mixed settings.
- Issues a flush pulse that clears the Bayer/edge line buffers.
- Sits between the board KEY/SW inputs, the CCD capture frame-valid signal, and the raw-to-gray/edge pipeline.

---
 rtl/edge_mode_ctrl_pkg.sv | 9 +
 rtl/key_debounce.sv | 31 +++
 rtl/edge_mode_ctrl.sv | 101 ++++++++++
 tb/tb_edge_mode_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/edge_mode_ctrl_pkg.sv
// edge_mode_ctrl_pkg: mode encodings, FSM states and threshold width shared by the edge-mode control block
package edge_mode_ctrl_pkg;
  localparam logic [1:0] MODE_RGB = 2'd0;
  localparam logic [1:0] MODE_GRAY = 2'd1;
  localparam logic [1:0] MODE_SOBX = 2'd2;
  localparam logic [1:0] MODE_SOBY = 2'd3;
  localparam int THRESH_W = 12;
  typedef enum logic [1:0] {IDLE, PENDING, FLUSH} state_t;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchronizer plus stability counter; one-cycle oPress on each debounced 1->0 transition
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic iKey,
  output logic oPress
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic keyMeta, keySync, keyState;
  logic [CW-1:0] cnt;
  always_ff @(posedge iCLK or negedge iRST)
    if (!iRST) begin
      keyMeta <= 1'b1;
      keySync <= 1'b1;
      keyState <= 1'b1;
      cnt <= '0;
      oPress <= 1'b0;
    end else begin
      keyMeta <= iKey;
      keySync <= keyMeta;
      oPress <= (keySync != keyState) && (cnt == LAST) && !keySync;
      if (keySync == keyState) cnt <= '0;
      else if (cnt == LAST) begin
        cnt <= '0;
        keyState <= keySync;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/edge_mode_ctrl.sv
// edge_mode_ctrl: debounced mode cycling with frame-boundary apply and line-buffer flush
// Optional EDGE_CTRL_AUTOCYCLE_EN: advance the mode every AUTO_FRAMES frames while iAUTO is high
module edge_mode_ctrl
  import edge_mode_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int FLUSH_CYCLES = 16,
  parameter int AUTO_FRAMES = 60
) (
  input  logic                iCLK,
  input  logic                iRST,
  input  logic                iKEY,
  input  logic [9:0]          iSW,
  input  logic                iFVAL,
  input  logic                iAUTO,
  output logic [1:0]          oMode,
  output logic [THRESH_W-1:0] oThresh,
  output logic                oFlush,
  output logic                oPending,
  output logic                oOverrun
);
  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  state_t state;
  logic keyPress, autoPress, press, fvalD, fvalD2, frameEnd, fvalRise;
  logic [9:0] swMeta, swSync;
  logic [1:0] pendMode;
  logic [FW-1:0] flushCnt;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
    .iCLK(iCLK), .iRST(iRST), .iKey(iKEY), .oPress(keyPress)
  );

`ifdef EDGE_CTRL_AUTOCYCLE_EN
  localparam int AW = $clog2(AUTO_FRAMES + 1);
  logic [AW-1:0] frameCnt;
  always_ff @(posedge iCLK or negedge iRST)
    if (!iRST) begin
      frameCnt <= '0;
      autoPress <= 1'b0;
    end else begin
      autoPress <= iAUTO && frameEnd && (frameCnt == AW'(AUTO_FRAMES - 1));
      if (!iAUTO) frameCnt <= '0;
      else if (frameEnd) frameCnt <= (frameCnt == AW'(AUTO_FRAMES - 1)) ? '0 : frameCnt + 1'b1;
    end
`else
  logic unusedAuto;
  assign unusedAuto = iAUTO & (AUTO_FRAMES > 0);
  assign autoPress = 1'b0;
`endif

  assign press = keyPress | autoPress;
  assign frameEnd = fvalD & ~iFVAL;
  assign fvalRise = fvalD & ~fvalD2;

  // a press coinciding with a frame end is only queued; the apply uses the pre-press pendMode
  always_ff @(posedge iCLK or negedge iRST)
    if (!iRST) begin
      state <= IDLE;
      fvalD <= 1'b0;
      fvalD2 <= 1'b0;
      swMeta <= '0;
      swSync <= '0;
      pendMode <= MODE_RGB;
      flushCnt <= '0;
      oMode <= MODE_RGB;
      oThresh <= '0;
      oFlush <= 1'b0;
      oPending <= 1'b0;
      oOverrun <= 1'b0;
    end else begin
      fvalD <= iFVAL;
      fvalD2 <= fvalD;
      swMeta <= iSW;
      swSync <= swMeta;
      if (press) begin
        pendMode <= (oPending ? pendMode : oMode) + 2'd1;
        oPending <= 1'b1;
      end
      if (oFlush && fvalRise) oOverrun <= 1'b1;
      case (state)
        IDLE: begin
          if (frameEnd) oThresh <= {swSync, 2'b00};
          if (press) state <= PENDING;
        end
        PENDING:
          if (frameEnd) begin
            oMode <= pendMode;
            oThresh <= {swSync, 2'b00};
            oPending <= press;
            oFlush <= 1'b1;
            flushCnt <= FW'(FLUSH_CYCLES - 1);
            state <= FLUSH;
          end
        default:
          if (flushCnt == '0) begin
            oFlush <= 1'b0;
            state <= (oPending || press) ? PENDING : IDLE;
          end else flushCnt <= flushCnt - 1'b1;
      endcase
    end
endmodule

// File: tb/tb_edge_mode_ctrl.sv
// tb_edge_mode_ctrl: scoreboard bench; stimulus queues expected output snapshots, a negedge monitor pops on each change
module tb_edge_mode_ctrl;
  logic clk = 1'b0, iRST = 1'b1, iKEY = 1'b1, iFVAL = 1'b0, iAUTO = 1'b0;
  logic [9:0] iSW = '0;
  logic [1:0] oMode;
  logic [11:0] oThresh;
  logic oFlush, oPending, oOverrun;
  logic [16:0] outs, prevOuts = '0, expv;
  logic prevRst = 1'b1;
  logic [16:0] expQ[$];
  int flushQ[$];
  int flushLen = 0, expLen = 0, total = 0, bad = 0;

  always #5 clk = ~clk;

  edge_mode_ctrl #(.DEBOUNCE_CYCLES(4), .FLUSH_CYCLES(3), .AUTO_FRAMES(2)) dut (
    .iCLK(clk), .iRST(iRST), .iKEY(iKEY), .iSW(iSW), .iFVAL(iFVAL), .iAUTO(iAUTO),
    .oMode(oMode), .oThresh(oThresh), .oFlush(oFlush), .oPending(oPending), .oOverrun(oOverrun)
  );

  assign outs = {oMode, oThresh, oFlush, oPending, oOverrun};

  function automatic logic [16:0] ev(logic [1:0] m, logic [11:0] t, logic f, logic p, logic o);
    return {m, t, f, p, o};
  endfunction

  always @(negedge clk) begin
    if (iRST !== prevRst || (iRST && outs !== prevOuts)) begin
      total++;
      if (expQ.size() == 0) begin
        bad++;
        $display("FAIL out_unexpected: got mode=%0d thr=%h flush=%b pend=%b ovr=%b, none expected",
                 oMode, oThresh, oFlush, oPending, oOverrun);
      end else begin
        expv = expQ.pop_front();
        if (outs !== expv) begin
          bad++;
          $display("FAIL out_snapshot: got mode=%0d thr=%h flush=%b pend=%b ovr=%b, want mode=%0d thr=%h flush=%b pend=%b ovr=%b",
                   oMode, oThresh, oFlush, oPending, oOverrun,
                   expv[16:15], expv[14:3], expv[2], expv[1], expv[0]);
        end
      end
    end
    if (!iRST) flushLen = 0;
    else if (oFlush) flushLen++;
    else if (flushLen > 0) begin
      total++;
      expLen = (flushQ.size() > 0) ? flushQ.pop_front() : 0;
      if (flushLen != expLen) begin
        bad++;
        $display("FAIL flush_len: got %0d cycles, want %0d", flushLen, expLen);
      end
      flushLen = 0;
    end
    prevRst = iRST;
    prevOuts = outs;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic press();
    iKEY = 1'b0;
    repeat (10) cyc();
    iKEY = 1'b1;
    repeat (10) cyc();
  endtask

  task automatic frame();
    iFVAL = 1'b1;
    repeat (4) cyc();
    iFVAL = 1'b0;
    repeat (8) cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    expQ.push_back(ev(0, 0, 0, 0, 0));
    expQ.push_back(ev(0, 0, 0, 0, 0));
    #3 iRST = 1'b0;
    repeat (3) cyc();
    iRST = 1'b1;
    repeat (3) cyc();
    // 1: press queued, applied at frame end with a 3-cycle flush
    expQ.push_back(ev(0, 0, 0, 1, 0));
    press();
    expQ.push_back(ev(1, 0, 1, 0, 0));
    expQ.push_back(ev(1, 0, 0, 0, 0));
    flushQ.push_back(3);
    frame();
    // 2: 3-cycle glitch is rejected
    iKEY = 1'b0;
    repeat (3) cyc();
    iKEY = 1'b1;
    repeat (10) cyc();
    frame();
    frame();
    // 3: reach mode 3, then two presses in one frame wrap to 1
    for (int m = 2; m <= 3; m++) begin
      expQ.push_back(ev(2'(m - 1), 0, 0, 1, 0));
      press();
      expQ.push_back(ev(2'(m), 0, 1, 0, 0));
      expQ.push_back(ev(2'(m), 0, 0, 0, 0));
      flushQ.push_back(3);
      frame();
    end
    expQ.push_back(ev(3, 0, 0, 1, 0));
    press();
    press();
    expQ.push_back(ev(1, 0, 1, 0, 0));
    expQ.push_back(ev(1, 0, 0, 0, 0));
    flushQ.push_back(3);
    frame();
    // 4: threshold refresh without flush
    iSW = 10'h3FF;
    expQ.push_back(ev(1, 12'hFFC, 0, 0, 0));
    frame();
    // 5: iFVAL re-rises one cycle after the frame end during flush
    expQ.push_back(ev(1, 12'hFFC, 0, 1, 0));
    press();
    expQ.push_back(ev(2, 12'hFFC, 1, 0, 0));
    expQ.push_back(ev(2, 12'hFFC, 1, 0, 1));
    expQ.push_back(ev(2, 12'hFFC, 0, 0, 1));
    flushQ.push_back(3);
    iFVAL = 1'b1;
    repeat (4) cyc();
    iFVAL = 1'b0;
    cyc();
    iFVAL = 1'b1;
    repeat (8) cyc();
    iFVAL = 1'b0;
    repeat (4) cyc();
    // 6: reset during flush with a press queued
    expQ.push_back(ev(2, 12'hFFC, 0, 1, 1));
    press();
    expQ.push_back(ev(3, 12'hFFC, 1, 0, 1));
    expQ.push_back(ev(3, 12'hFFC, 1, 1, 1));
    expQ.push_back(ev(0, 0, 0, 0, 0));
    expQ.push_back(ev(0, 0, 0, 0, 0));
    iFVAL = 1'b1;
    repeat (4) cyc();
    iKEY = 1'b0;
    repeat (4) cyc();
    iFVAL = 1'b0;
    repeat (3) cyc();
    @(negedge clk);
    #1 iRST = 1'b0;
    iKEY = 1'b1;
    repeat (3) cyc();
    iRST = 1'b1;
    repeat (3) cyc();
    expQ.push_back(ev(0, 12'hFFC, 0, 0, 0));
    frame();
    repeat (5) cyc();
    total++;
    if (expQ.size() != 0 || flushQ.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d snapshots and %0d flushes left, want 0 and 0", expQ.size(), flushQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
